// File: rtl/shftreg_window_n.sv
// C-channel N-deep bitstream shift register with sliding-window ones count,
// selectable delay tap, parallel preload and window-filled flag.
module shftreg_window_n #(
    parameter int N = 8,
    parameter int C = 4,
    localparam int CW = $clog2(N + 1),
    localparam int TW = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            EN,
    input  logic [C-1:0]    IN,
    input  logic            LOAD,
    input  logic [C*N-1:0]  LOAD_DATA,
    input  logic [TW-1:0]   TAP_SEL,
    output logic [C*N-1:0]  REG,
    output logic [C-1:0]    TAP_OUT,
    output logic [C*CW-1:0] CNT,
    output logic            FULL
);

    logic [N-1:0]  sr_q  [C];
    logic [CW-1:0] cnt_q [C];
    logic [CW-1:0] fill_q;
    logic          full_q;

    function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
        logic [CW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p = p + CW'(v[i]);
        return p;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < C; c++) begin
                sr_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
            fill_q <= '0;
            full_q <= 1'b0;
        end else if (LOAD) begin
            for (int c = 0; c < C; c++) begin
                sr_q[c]  <= LOAD_DATA[c*N +: N];
                cnt_q[c] <= popcnt(LOAD_DATA[c*N +: N]);
            end
            fill_q <= CW'(N);
            full_q <= 1'b1;
        end else if (EN) begin
            // count tracks the window: add the entering bit, drop the leaving one
            for (int c = 0; c < C; c++) begin
                sr_q[c]  <= {sr_q[c][N-2:0], IN[c]};
                cnt_q[c] <= cnt_q[c] + CW'(IN[c]) - CW'(sr_q[c][N-1]);
            end
            if (fill_q < CW'(N)) fill_q <= fill_q + 1'b1;
            if (int'(fill_q) + 1 >= N) full_q <= 1'b1;
        end
    end

    always_comb begin
        REG     = '0;
        CNT     = '0;
        TAP_OUT = '0;
        for (int c = 0; c < C; c++) begin
            REG[c*N +: N]   = sr_q[c];
            CNT[c*CW +: CW] = cnt_q[c];
            // selectors past the last stage read as 0 when N is not a power of 2
            TAP_OUT[c] = (int'(TAP_SEL) < N) ? sr_q[c][TAP_SEL] : 1'b0;
        end
    end

    assign FULL = full_q;

endmodule

// File: tb/tb_shftreg_window_n.sv
// Directed checks on an 8x4 instance plus a randomized scoreboard
// run on a 5x3 instance.
module tb_shftreg_window_n;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // instance A: N=8, C=4
    logic        a_rst, a_en, a_ld, a_full;
    logic [3:0]  a_in, a_tap;
    logic [31:0] a_ldd, a_reg;
    logic [2:0]  a_tsel;
    logic [15:0] a_cnt;

    shftreg_window_n #(.N(8), .C(4)) u_a (
        .CLK(CLK), .RESET(a_rst), .EN(a_en), .IN(a_in),
        .LOAD(a_ld), .LOAD_DATA(a_ldd), .TAP_SEL(a_tsel),
        .REG(a_reg), .TAP_OUT(a_tap), .CNT(a_cnt), .FULL(a_full)
    );

    // instance B: N=5, C=3
    logic        b_rst, b_en, b_ld, b_full;
    logic [2:0]  b_in, b_tap, b_tsel;
    logic [14:0] b_ldd, b_reg;
    logic [8:0]  b_cnt;

    shftreg_window_n #(.N(5), .C(3)) u_b (
        .CLK(CLK), .RESET(b_rst), .EN(b_en), .IN(b_in),
        .LOAD(b_ld), .LOAD_DATA(b_ldd), .TAP_SEL(b_tsel),
        .REG(b_reg), .TAP_OUT(b_tap), .CNT(b_cnt), .FULL(b_full)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_drive(input logic r, input logic e, input logic l,
                           input logic [3:0] i);
        a_rst = r; a_en = e; a_ld = l; a_in = i;
    endtask

    logic [4:0] m_reg [3];
    int         m_fill;
    logic       m_full;
    logic       r, l, e;
    logic [2:0] iv, ts;
    logic [14:0] ld;
    logic [4:0] sel;

    initial begin
        a_rst = 1; a_en = 0; a_ld = 0; a_in = 0; a_ldd = 0; a_tsel = 0;
        b_rst = 1; b_en = 0; b_ld = 0; b_in = 0; b_ldd = 0; b_tsel = 0;

        // 1: reset, then hold
        a_drive(1, 1, 1, 4'hF); a_ldd = 32'hFFFF_FFFF;
        tick(); tick();
        check("rst_reg", a_reg, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_full", a_full, 0);
        check("rst_tap", a_tap, 0);
        a_drive(0, 0, 0, 4'hF);
        for (int k = 0; k < 5; k++) tick();
        check("hold_reg", a_reg, 0);
        check("hold_cnt", a_cnt, 0);
        check("hold_full", a_full, 0);

        // 2: ones fill ch0, then drain
        for (int k = 1; k <= 8; k++) begin
            a_drive(0, 1, 0, 4'h1);
            tick();
            check($sformatf("fill_cnt0_%0d", k), a_cnt[3:0], k);
            check($sformatf("fill_full_%0d", k), a_full, (k == 8));
        end
        check("fill_reg0", a_reg[7:0], 8'hFF);
        check("fill_cnt_other", a_cnt[15:4], 0);
        for (int k = 7; k >= 0; k--) begin
            a_drive(0, 1, 0, 4'h0);
            tick();
            check($sformatf("drain_cnt0_%0d", k), a_cnt[3:0], k);
            check($sformatf("drain_full_%0d", k), a_full, 1);
        end

        // 3: ch1 stream with gapped EN
        begin
            logic [7:0] s;
            s = 8'b10110001;
            for (int k = 7; k >= 0; k--) begin
                a_drive(0, 1, 0, {2'b00, s[k], 1'b0});
                tick();
                a_drive(0, 0, 0, 4'hF);
                tick();
            end
        end
        check("gap_reg1", a_reg[15:8], 8'b10110001);
        check("gap_cnt1", a_cnt[7:4], 4);
        check("gap_reg0", a_reg[7:0], 0);
        a_tsel = 3; #1;
        check("tap3_ch1", a_tap[1], 0);
        a_tsel = 7; #1;
        check("tap7_ch1", a_tap[1], 1);
        a_tsel = 0; #1;
        check("tap0_ch1", a_tap[1], 1);

        // 4: load overrides shift
        a_ldd = {8'hFF, 8'hA5, 8'h00, 8'h3C};
        a_drive(0, 1, 1, 4'hF);
        tick();
        check("ld_reg", a_reg, 32'hFFA5_003C);
        check("ld_cnt2", a_cnt[11:8], 4);
        check("ld_cnt", a_cnt, 16'h8404);
        check("ld_full", a_full, 1);
        a_drive(0, 1, 0, 4'b1011);
        tick();
        check("ldsh_reg2", a_reg[23:16], 8'h4A);
        check("ldsh_cnt2", a_cnt[11:8], 3);
        check("ldsh_reg3", a_reg[31:24], 8'hFF);
        check("ldsh_cnt3", a_cnt[15:12], 8);

        // 5: reset beats load and enable
        a_drive(0, 1, 0, 4'hF); tick();
        a_drive(1, 1, 1, 4'hF);
        tick();
        check("rst2_reg", a_reg, 0);
        check("rst2_cnt", a_cnt, 0);
        check("rst2_full", a_full, 0);
        for (int k = 1; k <= 8; k++) begin
            a_drive(0, 1, 0, 4'hF);
            tick();
            check($sformatf("refill_full_%0d", k), a_full, (k == 8));
        end
        check("refill_cnt", a_cnt, 16'h8888);
        a_drive(0, 0, 0, 4'h0);

        // 6: randomized run against a model on the 5x3 instance
        b_rst = 1; tick();
        for (int c = 0; c < 3; c++) m_reg[c] = '0;
        m_fill = 0; m_full = 0;
        for (int k = 0; k < 10000; k++) begin
            r  = ($urandom_range(0, 499) == 0);
            l  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 9) < 6);
            iv = 3'($urandom);
            ld = 15'($urandom);
            ts = 3'($urandom_range(0, 7));
            b_rst = r; b_ld = l; b_en = e; b_in = iv;
            b_ldd = ld; b_tsel = ts;
            tick();
            if (r) begin
                for (int c = 0; c < 3; c++) m_reg[c] = '0;
                m_fill = 0; m_full = 0;
            end else if (l) begin
                for (int c = 0; c < 3; c++) m_reg[c] = ld[c*5 +: 5];
                m_fill = 5; m_full = 1;
            end else if (e) begin
                for (int c = 0; c < 3; c++)
                    m_reg[c] = {m_reg[c][3:0], iv[c]};
                if (m_fill + 1 >= 5) m_full = 1;
                if (m_fill < 5) m_fill++;
            end
            check("rnd_reg", b_reg, {m_reg[2], m_reg[1], m_reg[0]});
            check("rnd_full", b_full, m_full);
            for (int c = 0; c < 3; c++) begin
                sel = m_reg[c];
                check($sformatf("rnd_cnt%0d", c), b_cnt[c*3 +: 3],
                      $countones(sel));
                check($sformatf("rnd_tap%0d_sel%0d", c, ts), b_tap[c],
                      (ts < 5) ? sel[ts] : 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
